// File: rtl/reg_arb_pkg.sv
// Shared defaults and types for the register-bank write arbiter.
package reg_arb_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_ADDR_W   = 4;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/reg_addr_decoder.sv
// Register address to one-hot clock enable; all-zero when disabled or out of range.
module reg_addr_decoder #(
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 8
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    // NOTE: default assignment first keeps this always_comb free of inferred latches.
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (addr == ADDR_W'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port between ALU writeback (A) and load return (B).
// Define REG_ARB_STATS_EN to add transfer counters and the longest-stall statistic.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_valid,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  output logic                a_ready,
  input  logic                b_valid,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_data,
  output logic                b_ready,
  output logic [NUM_REGS-1:0] reg_ce,
  output logic [DATA_W-1:0]   reg_data,
  output logic                addr_err
`ifdef REG_ARB_STATS_EN
  ,
  output logic [15:0]         a_wr_count,
  output logic [15:0]         b_wr_count,
  output logic [7:0]          stall_max
`endif
);

  localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W + 1)'(NUM_REGS);

  req_id_e               last_grant;
  logic                  xfer;
  logic [ADDR_W-1:0]     win_addr;
  logic [DATA_W-1:0]     win_data;
  logic                  win_out_of_range;
  logic [NUM_REGS-1:0]   ce_next;

  // A wins unless B is also requesting and A was the last one served.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!reset) begin
      if (a_valid && (!b_valid || (last_grant == REQ_B))) a_ready = 1'b1;
      else if (b_valid)                                  b_ready = 1'b1;
    end
  end

  assign xfer             = a_ready | b_ready;
  assign win_addr         = b_ready ? b_addr : a_addr;
  assign win_data         = b_ready ? b_data : a_data;
  assign win_out_of_range = ({1'b0, win_addr} >= REG_LIMIT);

  reg_addr_decoder #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_decoder (
    .addr   (win_addr),
    .en     (xfer),
    .onehot (ce_next)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      last_grant <= REQ_B;
      reg_ce     <= '0;
      reg_data   <= '0;
      addr_err   <= 1'b0;
    end else begin
      reg_ce <= ce_next;
      if (xfer) begin
        reg_data   <= win_data;
        last_grant <= b_ready ? REQ_B : REQ_A;
        if (win_out_of_range) addr_err <= 1'b1;
      end
    end
  end

`ifdef REG_ARB_STATS_EN
  logic       stall;
  logic [7:0] stall_run;
  logic [7:0] stall_run_next;

  assign stall          = (a_valid & ~a_ready) | (b_valid & ~b_ready);
  assign stall_run_next = !stall ? 8'd0 : ((stall_run == 8'hFF) ? stall_run : stall_run + 8'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      a_wr_count <= '0;
      b_wr_count <= '0;
      stall_run  <= '0;
      stall_max  <= '0;
    end else begin
      if (a_ready) a_wr_count <= sat_inc16(a_wr_count);
      if (b_ready) b_wr_count <= sat_inc16(b_wr_count);
      stall_run <= stall_run_next;
      if (stall_run_next > stall_max) stall_max <= stall_run_next;
    end
  end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_reg_write_arbiter;
  import reg_arb_pkg::*;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_ready, b_ready, addr_err;
  logic [NR-1:0] reg_ce;
  logic [DW-1:0] reg_data;
`ifdef REG_ARB_STATS_EN
  logic [15:0]   a_wr_count, b_wr_count;
  logic [7:0]    stall_max;
`endif

  always #5 clk = ~clk;

  reg_write_arbiter #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .reg_ce(reg_ce), .reg_data(reg_data), .addr_err(addr_err)
`ifdef REG_ARB_STATS_EN
    , .a_wr_count(a_wr_count), .b_wr_count(b_wr_count), .stall_max(stall_max)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who is served this cycle, and what the bank sees next cycle.
  bit            m_on = 1'b0;
  bit            m_last_b;            // 1 when B was served most recently
  logic [NR-1:0] m_ce;
  logic [DW-1:0] m_data;
  bit            m_err;
  int            m_a_cnt, m_b_cnt, m_run, m_max;
  logic [DW-1:0] bank [NR];

  function automatic void exp_ready(output bit ea, output bit eb);
    ea = 1'b0;
    eb = 1'b0;
    if (!reset) begin
      if (a_valid && b_valid) begin
        ea = m_last_b;
        eb = !m_last_b;
      end else begin
        ea = a_valid;
        eb = b_valid;
      end
    end
  endfunction

  always @(posedge clk) begin
    bit ea, eb;
    int addr;
    for (int i = 0; i < NR; i++) if (reg_ce[i] === 1'b1) bank[i] = reg_data;
    exp_ready(ea, eb);
    if (reset) begin
      m_on = 1'b1; m_last_b = 1'b1; m_ce = '0; m_data = '0; m_err = 1'b0;
      m_a_cnt = 0; m_b_cnt = 0; m_run = 0; m_max = 0;
    end else begin
      m_ce = '0;
      if (ea || eb) begin
        addr     = eb ? int'(b_addr) : int'(a_addr);
        m_data   = eb ? b_data : a_data;
        m_last_b = eb;
        if (addr < NR) m_ce = NR'(1) << addr;
        else           m_err = 1'b1;
      end
      if (ea) m_a_cnt = (m_a_cnt == 65535) ? 65535 : m_a_cnt + 1;
      if (eb) m_b_cnt = (m_b_cnt == 65535) ? 65535 : m_b_cnt + 1;
      if ((a_valid && !ea) || (b_valid && !eb)) m_run = (m_run == 255) ? 255 : m_run + 1;
      else                                      m_run = 0;
      if (m_run > m_max) m_max = m_run;
    end
  end

  always @(negedge clk) begin
    bit ea, eb;
    if (m_on) begin
      exp_ready(ea, eb);
      check("a_ready", a_ready, ea);
      check("b_ready", b_ready, eb);
      check("reg_ce", reg_ce, m_ce);
      check("reg_data", reg_data, m_data);
      check("addr_err", addr_err, m_err);
`ifdef REG_ARB_STATS_EN
      check("a_wr_count", a_wr_count, m_a_cnt);
      check("b_wr_count", b_wr_count, m_b_cnt);
      check("stall_max", stall_max, m_max);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic drive_a(input bit v, input int addr, input logic [DW-1:0] d);
    a_valid = v; a_addr = AW'(addr); a_data = d;
  endtask

  task automatic drive_b(input bit v, input int addr, input logic [DW-1:0] d);
    b_valid = v; b_addr = AW'(addr); b_data = d;
  endtask

  bit acc_a, acc_b;

  initial begin
    // Reset state and A alone.
    do_reset();
    mid();
    check("rst_reg_ce", reg_ce, 0);
    check("rst_reg_data", reg_data, 0);
    check("rst_addr_err", addr_err, 0);
    drive_a(1, 3, 16'h1234);
    mid(); check("t1_a_ready", a_ready, 1);
    tick(); drive_a(0, 0, 0);
    mid(); check("t1_reg_ce", reg_ce, 8'b0000_1000); check("t1_reg_data", reg_data, 16'h1234);
    tick();

    // Tie from reset: A then B, then A wins again.
    do_reset();
    drive_a(1, 1, 16'h1111); drive_b(1, 2, 16'h2222);
    mid(); check("t2_a_first", a_ready, 1); check("t2_b_wait", b_ready, 0);
    tick(); drive_a(0, 0, 0);
    mid(); check("t2_b_next", b_ready, 1); check("t2_ce_a", reg_ce, 8'h02);
    tick(); drive_b(0, 0, 0);
    mid(); check("t2_ce_b", reg_ce, 8'h04); check("t2_data_b", reg_data, 16'h2222);
    tick(); drive_a(1, 6, 16'h6666); drive_b(1, 7, 16'h7777);
    mid(); check("t2_a_after_b", a_ready, 1);
    tick(); drive_a(0, 0, 0); drive_b(0, 0, 0);

    // Sustained tie alternates A,B,A,B,A,B.
    do_reset();
    drive_a(1, 0, 16'hA0A0); drive_b(1, 7, 16'hB0B0);
    for (int i = 0; i < 6; i++) begin
      mid();
      check("t3_a_grant", a_ready, (i % 2 == 0));
      check("t3_b_grant", b_ready, (i % 2 == 1));
      if (i > 0) check("t3_ce", reg_ce, (i % 2 == 1) ? 8'h01 : 8'h80);
      tick();
    end
    drive_a(0, 0, 0); drive_b(0, 0, 0);
    mid(); check("t3_ce_last", reg_ce, 8'h80);
    tick();

    // Same-register conflict with last grant A: B lands first, A overwrites.
    do_reset();
    drive_a(1, 0, 16'h0001);
    tick();
    drive_a(1, 5, 16'hAAAA); drive_b(1, 5, 16'hBBBB);
    mid(); check("t4_b_wins", b_ready, 1);
    tick(); drive_b(0, 0, 0);
    mid(); check("t4_a_next", a_ready, 1); check("t4_data_b", reg_data, 16'hBBBB);
    tick(); drive_a(0, 0, 0);
    mid(); check("t4_ce_a", reg_ce, 8'h20); check("t4_data_a", reg_data, 16'hAAAA);
    tick(); tick();
    check("t4_bank5", bank[5], 16'hAAAA);

    // Out-of-range address completes but writes nothing; error is sticky.
    do_reset();
    drive_b(1, 9, 16'h9999);
    mid(); check("t5_b_ready", b_ready, 1);
    tick(); drive_b(0, 0, 0);
    mid(); check("t5_ce", reg_ce, 0); check("t5_err", addr_err, 1);
    tick(); tick(); tick();
    mid(); check("t5_err_held", addr_err, 1);
    do_reset();
    mid(); check("t5_err_cleared", addr_err, 0);

    // Reset right after a transfer drops the pulse and re-arbitrates held requests.
    do_reset();
    drive_a(1, 2, 16'h2020);
    tick();
    reset = 1'b1; drive_a(1, 4, 16'h4040); drive_b(1, 6, 16'h6060);
    mid(); check("t6_a_ready_rst", a_ready, 0); check("t6_b_ready_rst", b_ready, 0);
    tick(); reset = 1'b0;
    mid(); check("t6_ce_dropped", reg_ce, 0); check("t6_a_rearb", a_ready, 1);
    tick(); drive_a(0, 0, 0); drive_b(0, 0, 0);
    tick();

`ifdef REG_ARB_STATS_EN
    do_reset();
    mid(); check("s_a_cnt_rst", a_wr_count, 0); check("s_b_cnt_rst", b_wr_count, 0);
    check("s_stall_rst", stall_max, 0);
    for (int i = 0; i < 3; i++) begin
      drive_a(1, i, DW'(i));
      tick();
    end
    drive_a(0, 0, 0);
    mid(); check("s_a_cnt_3", a_wr_count, 3);
    tick();
`endif

    // Randomized traffic: requests hold until accepted; occasional resets.
    do_reset();
    acc_a = 1'b1; acc_b = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (acc_a || !a_valid)
        drive_a($urandom_range(0, 2) != 0, $urandom_range(0, 9), DW'($urandom));
      if (acc_b || !b_valid)
        drive_b($urandom_range(0, 2) != 0, $urandom_range(0, 9), DW'($urandom));
      reset = ($urandom_range(0, 199) == 0);
      mid();
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      tick();
    end
    reset = 1'b0; drive_a(0, 0, 0); drive_b(0, 0, 0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
